// File: rtl/packetizer_da_arbiter.sv
// packetizer_da_arbiter: round-robin arbiter with bounded bursts feeding one packetizer_da injection port
// through a single registered pipeline stage.
module packetizer_da_arbiter #(
   parameter int NUM_PORTS        = 4,
   parameter int ADDRESS_WIDTH    = 4,
   parameter int VC_ADDRESS_WIDTH = 1,
   parameter int WIDTH_IN         = 12,
   parameter int MAX_BURST        = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic [NUM_PORTS*WIDTH_IN-1:0]          data_in,
   input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]     dst_in,
   input  logic [NUM_PORTS*VC_ADDRESS_WIDTH-1:0]  vc_in,
   input  logic [NUM_PORTS-1:0]                   valid_in,
   output logic [NUM_PORTS-1:0]                   ready_out,
   output logic [WIDTH_IN-1:0]                    data_out,
   output logic [ADDRESS_WIDTH-1:0]               dst_out,
   output logic [VC_ADDRESS_WIDTH-1:0]            vc_out,
   output logic                                   valid_out,
   input  logic                                   ready_in,
   output logic [NUM_PORTS-1:0]                   grant_out
);
   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] MB = CW'(MAX_BURST);

   if (NUM_PORTS < 2 || MAX_BURST < 1) begin : g_bad_params
      $fatal(1, "packetizer_da_arbiter: NUM_PORTS must be >=2 and MAX_BURST >=1");
   end

   logic [PW-1:0]               r_last;
   logic [CW-1:0]               r_cnt;
   logic [PW-1:0]               w_sel;
   logic                        w_any;
   logic                        w_load_en;
   logic [WIDTH_IN-1:0]         w_data;
   logic [ADDRESS_WIDTH-1:0]    w_dst;
   logic [VC_ADDRESS_WIDTH-1:0] w_vc;

   assign w_any     = |valid_in;
   assign w_load_en = !valid_out || ready_in;
   assign grant_out = w_any ? NUM_PORTS'(1) << w_sel : '0;
   assign ready_out = grant_out & {NUM_PORTS{w_load_en && !rst}};

   // Descending loop: the nearest valid port after r_last wins, r_last itself last.
   // cnt==0 only right after reset, so it never counts as an open burst.
   always_comb begin
      logic [PW-1:0] v_idx;
      w_sel = r_last;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         v_idx = PW'((int'(r_last) + k) % NUM_PORTS);
         if (valid_in[v_idx]) w_sel = v_idx;
      end
      if (valid_in[r_last] && r_cnt != '0 && r_cnt < MB) w_sel = r_last;
   end

   always_comb begin
      w_data = '0;
      w_dst  = '0;
      w_vc   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (w_sel == PW'(i)) begin
            w_data = data_in[i*WIDTH_IN +: WIDTH_IN];
            w_dst  = dst_in[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            w_vc   = vc_in[i*VC_ADDRESS_WIDTH +: VC_ADDRESS_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
         dst_out   <= '0;
         vc_out    <= '0;
         r_last    <= PW'(NUM_PORTS - 1);
         r_cnt     <= '0;
      end else if (w_load_en) begin
         valid_out <= w_any;
         if (w_any) begin
            data_out <= w_data;
            dst_out  <= w_dst;
            vc_out   <= w_vc;
            r_cnt    <= (w_sel == r_last && r_cnt < MB) ? r_cnt + CW'(1) : CW'(1);
            r_last   <= w_sel;
         end
      end
   end
endmodule

// File: tb/tb_packetizer_da_arbiter.sv
// tb_packetizer_da_arbiter: directed bench for packetizer_da_arbiter with burst lengths 4, 2 and 1
// sharing one set of requester inputs.
module tb_packetizer_da_arbiter;
   localparam int NP = 4, AW = 4, VW = 1, W = 12;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP*W-1:0]   data_in;
   logic [NP*AW-1:0]  dst_in;
   logic [NP*VW-1:0]  vc_in;
   logic [NP-1:0]     valid_in;
   logic              ready_in;

   logic [NP-1:0] r4, g4, r2, g2, r1, g1;
   logic [W-1:0]  d4, d2, d1;
   logic [AW-1:0] t4, t2, t1;
   logic [VW-1:0] c4, c2, c1;
   logic          v4, v2, v1;

   int n_chk = 0;
   int n_fail = 0;
   int seq[NP];

   packetizer_da_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_IN(W), .MAX_BURST(4)) u_b4 (
      .clk(clk), .rst(rst), .data_in(data_in), .dst_in(dst_in), .vc_in(vc_in), .valid_in(valid_in),
      .ready_out(r4), .data_out(d4), .dst_out(t4), .vc_out(c4), .valid_out(v4), .ready_in(ready_in), .grant_out(g4));
   packetizer_da_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_IN(W), .MAX_BURST(2)) u_b2 (
      .clk(clk), .rst(rst), .data_in(data_in), .dst_in(dst_in), .vc_in(vc_in), .valid_in(valid_in),
      .ready_out(r2), .data_out(d2), .dst_out(t2), .vc_out(c2), .valid_out(v2), .ready_in(ready_in), .grant_out(g2));
   packetizer_da_arbiter #(.NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .VC_ADDRESS_WIDTH(VW), .WIDTH_IN(W), .MAX_BURST(1)) u_b1 (
      .clk(clk), .rst(rst), .data_in(data_in), .dst_in(dst_in), .vc_in(vc_in), .valid_in(valid_in),
      .ready_out(r1), .data_out(d1), .dst_out(t1), .vc_out(c1), .valid_out(v1), .ready_in(ready_in), .grant_out(g1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int p = 0; p < NP; p++) data_in[p*W +: W] = W'((p << 8) | seq[p]);
   endtask

   task automatic clear_seq();
      for (int p = 0; p < NP; p++) seq[p] = 0;
      drive();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requesters advance their word only when accepted in the cycle just ended.
   task automatic cycle();
      logic [NP-1:0] acc;
      acc = r4;
      tick();
      for (int p = 0; p < NP; p++) if (acc[p]) seq[p]++;
      drive();
   endtask

   task automatic word(input string tag, input int p, input int s);
      chk({tag, "_data"}, d4, (p << 8) | s);
      chk({tag, "_dst"}, t4, p + 4);
      chk({tag, "_vc"}, c4, p & 1);
      chk({tag, "_valid"}, v4, 1);
   endtask

   task automatic rst_pulse();
      rst = 1'b1;
      #1;
      rst = 1'b0;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      int e4[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
      int e2[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int e1[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
      int ebp[6][2] = '{'{2, 1}, '{3, 0}, '{3, 1}, '{3, 2}, '{3, 3}, '{0, 0}};
      ready_in = 1'b1;
      dst_in   = {4'd7, 4'd6, 4'd5, 4'd4};
      vc_in    = 4'b1010;
      valid_in = 4'($urandom_range(1, 15));
      clear_seq();
      // reset with random requests
      repeat (2) tick();
      chk("rst_valid", v4, 0);
      chk("rst_ready", r4, 0);
      chk("rst_data", d4, 0);
      chk("rst_ready_b1", r1, 0);
      valid_in = 4'hF;
      #1;
      chk("rst_ready_all", r4, 0);
      rst = 1'b0;
      #1;
      chk("first_grant_b4", g4, 4'b0001);
      chk("first_ready_b4", r4, 4'b0001);
      chk("first_grant_b2", g2, 4'b0001);
      chk("first_grant_b1", g1, 4'b0001);
      // fairness with all ports requesting
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("fair_b4", d4, e4[i] << 8);
         chk("fair_b2", d2, e2[i] << 8);
         chk("fair_b1", d1, e1[i] << 8);
         chk("fair_valid", v4, 1);
      end
      // async reset while port 2 holds a burst at cnt=2
      tick();
      word("pre_rst", 2, 0);
      rst = 1'b1;
      #1;
      chk("async_valid", v4, 0);
      chk("async_data", d4, 0);
      chk("async_ready", r4, 0);
      chk("async_valid_b2", v2, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_grant", g4, 4'b0001);
      tick();
      word("post_rst", 0, 0);
      // single port streaming across burst expiries
      rst_pulse();
      valid_in = 4'b0100;
      for (int k = 1; k <= 10; k++) begin
         data_in[2*W +: W] = W'(k);
         #1;
         chk("single_ready", r4, 4'b0100);
         tick();
         chk("single_data", d4, k);
         chk("single_valid", v4, 1);
      end
      // backpressure (port 2 holds last=2, cnt=2)
      clear_seq();
      valid_in = 4'hF;
      cycle();
      word("bp_pre", 2, 0);
      ready_in = 1'b0;
      repeat (5) begin
         #1;
         chk("bp_ready", r4, 0);
         chk("bp_grant", g4, 4'b0100);
         cycle();
         word("bp_hold", 2, 0);
      end
      ready_in = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         word("bp_resume", ebp[i][0], ebp[i][1]);
      end
      // burst break and owner return
      rst_pulse();
      clear_seq();
      valid_in = 4'b0001;
      cycle();
      word("brk_p0", 0, 0);
      valid_in = 4'b1000;
      #1;
      chk("brk_grant3", g4, 4'b1000);
      cycle();
      word("brk_p3", 3, 0);
      valid_in = 4'b0001;
      #1;
      chk("brk_grant0", g4, 4'b0001);
      cycle();
      word("brk_ret", 0, 1);
      valid_in = 4'b1001;
      for (int s = 2; s <= 4; s++) begin
         cycle();
         word("brk_burst", 0, s);
      end
      cycle();
      word("brk_next", 3, 1);
      // idle drains the output stage
      valid_in = 4'b0000;
      #1;
      chk("idle_grant", g4, 0);
      chk("idle_ready", r4, 0);
      tick();
      chk("idle_valid", v4, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
